// File: rtl/l2_port_arbiter_n.sv
// N-port arbiter sharing one L2 block port between several L1 requesters.
// Selects a winner (fixed priority or round-robin), issues the block request
// to L2, passes the word stream through for the granted port, and pulses
// done_o when the last word of the block has moved.
//
// Handshake semantics:
//   - A requester holds req_i[k] (with stable rw_i/add_i) until it samples
//     done_o[k]. The grant is decided only in IDLE, so req_i changes on
//     ports other than the granted one are invisible until the next IDLE.
//   - l2_req_o is held high from the cycle after the grant until the last
//     word moves. l2_ack_i in ISSUE accepts the request; no word moves in
//     that cycle, even if l2_valid_i is also high.
//   - In XFER every cycle with l2_valid_i high moves exactly one word:
//     ready_o[g] mirrors it combinationally, so the L1 side sees read data
//     on data_o or has its data_i word consumed in that same cycle.
//     l2_valid_i outside XFER is ignored.
module l2_port_arbiter_n #(
   parameter int N_PORTS     = 2,
   parameter int BW_ADDR     = 24,
   parameter int BW_DATA     = 32,
   parameter int BLOCK_WORDS = 16,
   parameter int ARB_MODE    = 1
) (
   input  logic                         clock_i,
   input  logic                         resetn_i,
   input  logic [N_PORTS-1:0]           req_i,
   input  logic [N_PORTS-1:0]           rw_i,
   input  logic [N_PORTS*BW_ADDR-1:0]   add_i,
   input  logic [N_PORTS*BW_DATA-1:0]   data_i,
   output logic [N_PORTS-1:0]           ready_o,
   output logic [BW_DATA-1:0]           data_o,
   output logic [N_PORTS-1:0]           done_o,
   output logic [N_PORTS-1:0]           grant_o,
   output logic                         l2_req_o,
   output logic                         l2_rw_o,
   output logic [BW_ADDR-1:0]           l2_add_o,
   output logic [BW_DATA-1:0]           l2_data_o,
   input  logic                         l2_ack_i,
   input  logic                         l2_valid_i,
   input  logic [BW_DATA-1:0]           l2_data_i,
   output logic [31:0]                  conflict_count_o
);

   localparam int PW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
   localparam int CW = $clog2(BLOCK_WORDS);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_XFER  = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   logic [1:0]             state;
   logic [PW-1:0]          ptr;
   logic [PW-1:0]          gidx;
   logic [CW-1:0]          wcnt;

   logic [2*N_PORTS-1:0]   req_dbl;
   logic [N_PORTS-1:0]     req_rot;
   logic [PW-1:0]          off;
   logic [PW:0]            sum;
   logic [PW-1:0]          win;
   logic [PW-1:0]          ptr_nxt;

   // Rotate requests so the search starts at the round-robin pointer
   assign req_dbl = {req_i, req_i} >> ptr;
   assign req_rot = (ARB_MODE != 0) ? req_dbl[N_PORTS-1:0] : req_i;

   // Offset of the first set request in the (possibly rotated) vector
   always_comb begin
      off = '0;
      for (int k = N_PORTS-1; k >= 0; k--) begin
         if (req_rot[k]) off = PW'(k);
      end
   end

   // Map the offset back to a port index, wrapping modulo N_PORTS
   always_comb begin
      sum = {1'b0, ptr} + {1'b0, off};
      if (ARB_MODE == 0)
         win = off;
      else if (sum >= (PW+1)'(N_PORTS))
         win = PW'(sum - (PW+1)'(N_PORTS));
      else
         win = PW'(sum);
   end

   assign ptr_nxt = (gidx == PW'(N_PORTS-1)) ? '0 : gidx + 1'b1;

   // Pass-through paths for the granted port; quiet when nothing is granted
   always_comb begin
      ready_o   = '0;
      data_o    = '0;
      l2_data_o = '0;
      if (state == S_XFER && l2_valid_i) ready_o = grant_o;
      if (|grant_o) begin
         data_o    = l2_data_i;
         l2_data_o = data_i[int'(gidx)*BW_DATA +: BW_DATA];
      end
   end

   // Control FSM: grant, L2 request, word counting, completion, counters
   always_ff @(posedge clock_i or negedge resetn_i) begin
      if (!resetn_i) begin
         state            <= S_IDLE;
         ptr              <= '0;
         gidx             <= '0;
         wcnt             <= '0;
         grant_o          <= '0;
         done_o           <= '0;
         l2_req_o         <= 1'b0;
         l2_rw_o          <= 1'b0;
         l2_add_o         <= '0;
         conflict_count_o <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (|req_i) begin
                  state    <= S_ISSUE;
                  gidx     <= win;
                  grant_o  <= {{(N_PORTS-1){1'b0}}, 1'b1} << win;
                  l2_req_o <= 1'b1;
                  l2_add_o <= add_i[int'(win)*BW_ADDR +: BW_ADDR];
                  l2_rw_o  <= rw_i[win];
                  if ($countones(req_i) > 1 && conflict_count_o != 32'hFFFF_FFFF)
                     conflict_count_o <= conflict_count_o + 32'd1;
               end
            end
            S_ISSUE: begin
               if (l2_ack_i) begin
                  state <= S_XFER;
                  wcnt  <= '0;
               end
            end
            S_XFER: begin
               if (l2_valid_i) begin
                  wcnt <= wcnt + 1'b1;
                  if (wcnt == CW'(BLOCK_WORDS-1)) begin
                     state    <= S_DONE;
                     done_o   <= grant_o;
                     l2_req_o <= 1'b0;
                  end
               end
            end
            S_DONE: begin
               state   <= S_IDLE;
               done_o  <= '0;
               grant_o <= '0;
               if (ARB_MODE != 0) ptr <= ptr_nxt;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_l2_port_arbiter_n.sv
// Bench for l2_port_arbiter_n: a round-robin and a fixed-priority instance
// (4 ports, 16-word blocks) share one stimulus; use_fp selects which one is
// checked. An arbitration model picks the expected winner from the request
// vector, and a queue holds the expected read words.
module tb_l2_port_arbiter_n;

   localparam int NP = 4;
   localparam int BW = 16;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic [NP-1:0]   req = '0;
   logic [NP-1:0]   rw = '0;
   logic [NP*24-1:0] add = '0;
   logic [NP*32-1:0] wdata = '0;
   logic            l2_ack = 1'b0;
   logic            l2_valid = 1'b0;
   logic [31:0]     l2_rdata = 32'hDEAD_BEEF;
   logic            use_fp = 1'b0;

   logic [NP-1:0]   ready_rr, done_rr, grant_rr, ready_fp, done_fp, grant_fp;
   logic [31:0]     data_rr, data_fp, l2d_rr, l2d_fp, conf_rr, conf_fp;
   logic            l2req_rr, l2req_fp, l2rw_rr, l2rw_fp;
   logic [23:0]     l2add_rr, l2add_fp;

   logic [NP-1:0]   ready_s, done_s, grant_s;
   logic [31:0]     data_s, l2d_s, conf_s;
   logic            l2req_s, l2rw_s;
   logic [23:0]     l2add_s;

   int              n_assert = 0;
   int              n_fail = 0;
   int              mode = 1;
   int              mptr = 0;
   int              exp_conf = 0;
   int              last_g = 0;
   logic [31:0]     exp_q[$];

   l2_port_arbiter_n #(.N_PORTS(NP), .BW_ADDR(24), .BW_DATA(32), .BLOCK_WORDS(BW), .ARB_MODE(1)) u_rr (
      .clock_i(clk), .resetn_i(rst_n), .req_i(req), .rw_i(rw), .add_i(add), .data_i(wdata),
      .ready_o(ready_rr), .data_o(data_rr), .done_o(done_rr), .grant_o(grant_rr),
      .l2_req_o(l2req_rr), .l2_rw_o(l2rw_rr), .l2_add_o(l2add_rr), .l2_data_o(l2d_rr),
      .l2_ack_i(l2_ack), .l2_valid_i(l2_valid), .l2_data_i(l2_rdata), .conflict_count_o(conf_rr));

   l2_port_arbiter_n #(.N_PORTS(NP), .BW_ADDR(24), .BW_DATA(32), .BLOCK_WORDS(BW), .ARB_MODE(0)) u_fp (
      .clock_i(clk), .resetn_i(rst_n), .req_i(req), .rw_i(rw), .add_i(add), .data_i(wdata),
      .ready_o(ready_fp), .data_o(data_fp), .done_o(done_fp), .grant_o(grant_fp),
      .l2_req_o(l2req_fp), .l2_rw_o(l2rw_fp), .l2_add_o(l2add_fp), .l2_data_o(l2d_fp),
      .l2_ack_i(l2_ack), .l2_valid_i(l2_valid), .l2_data_i(l2_rdata), .conflict_count_o(conf_fp));

   assign ready_s = use_fp ? ready_fp : ready_rr;
   assign done_s  = use_fp ? done_fp  : done_rr;
   assign grant_s = use_fp ? grant_fp : grant_rr;
   assign data_s  = use_fp ? data_fp  : data_rr;
   assign l2d_s   = use_fp ? l2d_fp   : l2d_rr;
   assign conf_s  = use_fp ? conf_fp  : conf_rr;
   assign l2req_s = use_fp ? l2req_fp : l2req_rr;
   assign l2rw_s  = use_fp ? l2rw_fp  : l2rw_rr;
   assign l2add_s = use_fp ? l2add_fp : l2add_rr;

   // Clock
   always #5 clk = ~clk;

   // Hard stop in case a handshake never completes
   initial begin
      #2_000_000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "bench timeout");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_assert++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Arbitration rule: lowest index, or first index at/after the pointer
   function automatic int pick(input logic [NP-1:0] r);
      for (int k = 0; k < NP; k++) begin
         int idx;
         idx = (mode == 0) ? k : (mptr + k) % NP;
         if (r[idx]) return idx;
      end
      return -1;
   endfunction

   function automatic logic [31:0] wword(input int p, input int w);
      return (p == 0) ? 32'hA0 + 32'(w) : 32'(p << 24) + 32'(w);
   endfunction

   task automatic raise(input int p, input logic r);
      if (!req[p]) begin
         req[p] = 1'b1;
         rw[p]  = r;
         add[p*24 +: 24] = 24'($urandom) & 24'hFFFFF0;
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      req = '0;
      l2_ack = 1'b0;
      l2_valid = 1'b0;
      exp_q.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      mptr = 0;
      exp_conf = 0;
   endtask

   // One IDLE cycle between blocks
   task automatic idle_step();
      @(negedge clk);
      l2_ack = 1'b0;
      l2_valid = 1'($urandom_range(0, 1));
      #1;
      check("idle_grant", 32'(grant_s), 0);
      check("idle_l2_req", 32'(l2req_s), 0);
      check("idle_done", 32'(done_s), 0);
      check("idle_ready", 32'(ready_s), 0);
   endtask

   // One block: grant, ack after ack_dly cycles, 16 words, done.
   // stall: 0 = none, 1 = alternate bubbles, 2 = random bubbles.
   task automatic do_block(input int ack_dly, input int stall, input bit rnd_data,
                           input int abort_at, input bit drop_mid);
      int g, w, guard;
      g = pick(req);
      last_g = g;
      if ($countones(req) > 1) exp_conf++;
      for (int i = 0; i < BW; i++) exp_q.push_back(rnd_data ? $urandom : 32'(i));
      @(negedge clk);
      l2_ack = 1'b0;
      l2_valid = 1'b0;
      #1;
      check("grant", 32'(grant_s), 32'(1 << g));
      check("l2_req", 32'(l2req_s), 1);
      check("l2_add", 32'(l2add_s), 32'(add[g*24 +: 24]));
      check("l2_rw", 32'(l2rw_s), 32'(rw[g]));
      repeat (ack_dly) begin
         @(negedge clk);
         l2_valid = 1'($urandom_range(0, 1));
         #1;
         check("issue_ready", 32'(ready_s), 0);
         check("issue_l2_req", 32'(l2req_s), 1);
      end
      @(negedge clk);
      l2_ack = 1'b1;
      l2_valid = 1'b1;
      #1;
      check("ack_ready", 32'(ready_s), 0);
      w = 0;
      guard = 0;
      while (w < BW && w != abort_at && guard < 400) begin
         @(negedge clk);
         guard++;
         l2_ack = 1'b0;
         l2_valid = (stall == 0) ? 1'b1 : (stall == 1) ? guard[0] : 1'($urandom_range(0, 1));
         wdata[g*32 +: 32] = wword(g, w);
         l2_rdata = l2_valid ? exp_q[0] : $urandom;
         if (drop_mid && w == 5) req[g] = 1'b0;
         if (stall == 2 && $urandom_range(0, 7) == 0) begin
            int p;
            p = int'($urandom_range(0, NP-1));
            if (p != g) raise(p, 1'($urandom_range(0, 1)));
         end
         #1;
         if (l2_valid) begin
            check("ready", 32'(ready_s), 32'(1 << g));
            if (rw[g]) check("l2_data_o", l2d_s, wword(g, w));
            else       check("data_o", data_s, exp_q.pop_front());
            w++;
         end else begin
            check("bubble_ready", 32'(ready_s), 0);
            if (rw[g]) check("l2_data_hold", l2d_s, wword(g, w));
         end
      end
      if (guard >= 400) check("xfer_timeout", 32'(w), BW);
      if (abort_at >= 0) begin
         exp_q.delete();
         return;
      end
      @(negedge clk);
      l2_valid = 1'($urandom_range(0, 1));
      #1;
      check("done", 32'(done_s), 32'(1 << g));
      check("done_l2_req", 32'(l2req_s), 0);
      check("done_ready", 32'(ready_s), 0);
      req[g] = 1'b0;
      if (mode == 1) mptr = (g + 1) % NP;
   endtask

   // Reset-state checks shared by power-on and mid-transfer reset
   task automatic check_reset_vals(input string tag);
      check({tag, "_grant"}, 32'(grant_s), 0);
      check({tag, "_done"}, 32'(done_s), 0);
      check({tag, "_l2_req"}, 32'(l2req_s), 0);
      check({tag, "_l2_rw"}, 32'(l2rw_s), 0);
      check({tag, "_l2_add"}, 32'(l2add_s), 0);
      check({tag, "_ready"}, 32'(ready_s), 0);
      check({tag, "_data_o"}, data_s, 0);
      check({tag, "_l2_data_o"}, l2d_s, 0);
      check({tag, "_conflict"}, conf_s, 0);
   endtask

   initial begin
      // Power-on reset
      wdata = {4{32'h5A5A_1234}};
      l2_valid = 1'b1;
      #1;
      check_reset_vals("por");
      l2_valid = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // Single read, port 1, address 0x000100, immediate ack, words 0..15
      use_fp = 1'b0;
      mode = 1;
      raise(1, 1'b0);
      add[1*24 +: 24] = 24'h000100;
      do_block(0, 0, 1'b0, -1, 1'b0);
      check("single_conflict", conf_s, 32'(exp_conf));

      // Write with delayed ack and alternate-cycle bubbles, port 0
      idle_step();
      raise(0, 1'b1);
      do_block(3, 1, 1'b0, -1, 1'b0);

      // Round-robin fairness: all ports re-request after their done
      do_reset();
      for (int p = 0; p < NP; p++) raise(p, 1'b0);
      for (int i = 0; i < 5; i++) begin
         do_block(0, 0, 1'b1, -1, 1'b0);
         if (i < 4) begin
            idle_step();
            raise(last_g, 1'b0);
         end
      end
      check("rr_conflict", conf_s, 32'(exp_conf));

      // Fixed priority: ports 0 and 2, port 0 re-requests at once
      do_reset();
      use_fp = 1'b1;
      mode = 0;
      raise(0, 1'b0);
      raise(2, 1'b0);
      do_block(0, 0, 1'b1, -1, 1'b0);
      idle_step();
      raise(0, 1'b0);
      do_block(1, 0, 1'b1, -1, 1'b0);
      idle_step();
      do_block(0, 0, 1'b1, -1, 1'b0);
      check("fp_conflict", conf_s, 32'(exp_conf));

      // Reset after 7 read words; no done, then a clean block
      do_reset();
      use_fp = 1'b0;
      mode = 1;
      raise(1, 1'b0);
      add[1*24 +: 24] = 24'h000230;
      do_block(0, 0, 1'b1, 7, 1'b0);
      @(negedge clk);
      rst_n = 1'b0;
      l2_valid = 1'b1;
      #1;
      check_reset_vals("midrst");
      repeat (3) begin
         @(negedge clk);
         #1;
         check("midrst_no_done", 32'(done_s), 0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      l2_valid = 1'b0;
      mptr = 0;
      exp_conf = 0;
      do_block(1, 2, 1'b1, -1, 1'b0);

      // Randomised traffic on the round-robin instance
      for (int i = 0; i < 12; i++) begin
         idle_step();
         for (int p = 0; p < NP; p++)
            if ($urandom_range(0, 1) == 1) raise(p, 1'($urandom_range(0, 1)));
         if (req == '0) raise(int'($urandom_range(0, NP-1)), 1'($urandom_range(0, 1)));
         do_block(int'($urandom_range(0, 3)), 2, 1'b1, -1, i == 3);
      end
      check("rand_conflict", conf_s, 32'(exp_conf));

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/l2_port_arbiter_n.md
# l2_port_arbiter_n

Parametrised N-port arbiter that shares one L2 cache port between N L1 requesters: instruction, data, or additional harts' L1s. It is the generalised successor of the fixed two-requester L1I/L1D-to-L2 routing in the internal memory controller. It adds the following:
- selectable fixed-priority or round-robin arbitration;
- full-block burst transfer sequencing;
- a contention counter for performance metrics.

It sits between the L1 caches and the L2 `L1_*` interface.

## Interface
Parameters:
- `N_PORTS`, 2: number of L1 requesters; legal range 2..8.
- `BW_ADDR`, 24: word-address width.
- `BW_DATA`, 32: data word width.
- `BLOCK_WORDS`, 16: words per cache block; power of two, at least 2.
- `ARB_MODE`, 1: 0 = fixed priority (lowest index wins); 1 = round-robin.

Ports (direction, width, meaning):
- `clock_i`, in, 1: single clock; all logic is on the rising edge.
- `resetn_i`, in, 1: asynchronous, active-low reset.
- `req_i`, in, N_PORTS: per-port block request. Held until that port's `done_o`.
- `rw_i`, in, N_PORTS: per-port direction; 1 = write block to L2, 0 = read.
- `add_i`, in, N_PORTS*BW_ADDR: per-port block-aligned word address. Port k occupies slice [k*BW_ADDR +: BW_ADDR].
- `data_i`, in, N_PORTS*BW_DATA: per-port write-data stream, sliced the same way.
- `ready_o`, out, N_PORTS: per-port word strobe. On a read, `data_o` is valid; on a write, the current `data_i` word is consumed.
- `data_o`, out, BW_DATA: read data, broadcast to all ports.
- `done_o`, out, N_PORTS: one-cycle block-complete pulse for the granted port.
- `grant_o`, out, N_PORTS: one-hot grant; all zero when idle.
- `l2_req_o`, out, 1: block request to L2.
- `l2_rw_o`, out, 1: direction of the granted request.
- `l2_add_o`, out, BW_ADDR: latched address of the granted request.
- `l2_data_o`, out, BW_DATA: write word to L2.
- `l2_ack_i`, in, 1: L2 has accepted the request.
- `l2_valid_i`, in, 1: per-word strobe from L2 (read data valid, or write word taken).
- `l2_data_i`, in, BW_DATA: read word from L2.
- `conflict_count_o`, out, 32: saturating count of contended grants.

## Operation
State machine states: IDLE, ISSUE, XFER, DONE.

- **IDLE**
  - If any `req_i` bit is set, select a winner g and register `grant_o` = one-hot(g).
  - Latch `add_i[g]` and `rw_i[g]`, then go to ISSUE.
  - If no request is pending, stay in IDLE.
- **Winner selection**
  - `ARB_MODE`=0: lowest set index.
  - `ARB_MODE`=1: first set index at or after round-robin pointer `ptr`, wrapping modulo N_PORTS.
- **ISSUE**
  - `l2_req_o`=1 with the latched `l2_add_o` and `l2_rw_o`.
  - On `l2_ack_i`=1, clear the word counter and go to XFER. Otherwise hold.
- **XFER**
  - `l2_req_o` stays 1.
  - `ready_o[g]` = `l2_valid_i`, combinational; all other `ready_o` bits are 0.
  - `data_o` = `l2_data_i`, combinational.
  - `l2_data_o` = `data_i[g]`, combinational.
  - The word counter (log2(BLOCK_WORDS) bits) increments on each `l2_valid_i`.
  - `l2_valid_i` while the counter equals BLOCK_WORDS-1: go to DONE.
- **DONE**
  - `done_o[g]`=1 and `l2_req_o`=0.
  - In round-robin mode, `ptr` ← (g+1) mod N_PORTS.
  - `grant_o` clears on exit. Next state is IDLE.
- **Contention counter:** `conflict_count_o` increments on an IDLE→ISSUE transition when at least two `req_i` bits are set. It saturates at 0xFFFFFFFF.
- **Requester protocol:** a requester drops `req_i` on the same edge it samples `done_o`. It therefore cannot be re-granted in the following IDLE cycle unless it raises `req_i` again.
- **Boundary conditions**
  - `req_i[g]` deasserted mid-transfer is a protocol violation; the block still completes and `done_o[g]` still pulses.
  - `l2_valid_i` in IDLE, ISSUE or DONE is ignored.
  - `l2_ack_i` together with `l2_valid_i` in ISSUE: only the ack is taken; no word is counted.
  - Changing `req_i` of non-granted ports has no effect until IDLE.

## Timing
- **Reset:** asynchronous assert, synchronous-safe release. Reset values:
  - state = IDLE, `ptr` = 0, word counter = 0, `conflict_count_o` = 0;
  - `grant_o` = 0, `done_o` = 0, `l2_req_o` = 0, `l2_rw_o` = 0, `l2_add_o` = 0.
  - `ready_o` = 0 and `data_o`/`l2_data_o` follow their pass-through sources gated by grant; with no grant they are 0.
- **Reset mid-transfer:** returns to IDLE immediately. No `done_o` is issued. L2 must also be reset.
- **Latency:** request seen at edge 0 → `grant_o` and `l2_req_o` high in cycle 1.
  - With `l2_ack_i` in cycle 1 and `l2_valid_i` every cycle: words transfer in cycles 2..BLOCK_WORDS+1.
  - `done_o` pulses in cycle BLOCK_WORDS+2; IDLE in cycle BLOCK_WORDS+3.
  - Minimum per-block occupancy is BLOCK_WORDS+3 cycles.
- **Throughput:** one word per cycle maximum. L2 may insert any number of bubbles by holding `l2_valid_i` low.
- **Registered outputs:** `grant_o`, `done_o`, `l2_req_o`, `l2_rw_o` and `l2_add_o` are registered. The `ready_o` and data paths are combinational.

## Test plan
- **Single read:** N_PORTS=2, BLOCK_WORDS=16, port 1 read at address 0x000100, L2 acks in cycle 1 with 16 back-to-back words 0..15.
  - Required response: `ready_o`=2'b10 for 16 cycles, `data_o` sequence 0..15, `done_o`=2'b10 in cycle 18, `conflict_count_o`=0.
- **Round-robin fairness:** N_PORTS=4, ARB_MODE=1, all four ports request reads continuously and re-request the cycle after their `done_o`.
  - Required response: grant order 0,1,2,3,0; `conflict_count_o`=5 after 5 blocks.
- **Fixed priority:** ARB_MODE=0, ports 0 and 2 request simultaneously, and port 0 re-requests immediately after its done.
  - Required response: port 0 is granted twice before port 2.
- **Write with stalls:** port 0 writes words 0xA0..0xAF; L2 delays `l2_ack_i` 3 cycles and drops `l2_valid_i` every other cycle.
  - Required response: `l2_data_o` presents each word until consumed, and exactly 16 `ready_o[0]` strobes occur.
- **Reset mid-transfer:** `resetn_i` is asserted low after 7 read words.
  - Required response: all outputs return to reset values immediately, and no `done_o` is issued.
  - After release, a new request completes normally starting from word 0.
